// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with 16x oversampling and a show-ahead byte FIFO
module uart_rx_fifo #(
  parameter int DIVISOR    = 651,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din,
  input  logic                pop,
  input  logic                clr_err,
  output logic [7:0]          rx_data,
  output logic                rx_valid,
  output logic [DEPTH_LOG2:0] level,
  output logic                frame_err,
  output logic                overrun,
  output logic                irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DW    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIVISOR - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic                  r_sync1, r_sync2;
  logic                  w_rxs;
  logic [DW-1:0]         r_div;
  logic                  w_tick;
  logic                  w_start;
  state_t                r_state, w_state_nxt;
  logic [3:0]            r_scnt, w_scnt_nxt;
  logic [2:0]            r_bcnt, w_bcnt_nxt;
  logic [7:0]            r_shift, w_shift_nxt;
  logic                  w_push_req, w_ferr_set;
  logic                  r_push;
  logic [7:0]            r_push_data;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [LW-1:0]         r_level;
  logic                  r_ferr, r_ovr;
  logic                  w_full, w_empty, w_do_pop, w_do_push, w_ovr_set;

  assign w_rxs   = r_sync2;
  assign w_tick  = (r_div == DIV_LAST);
  assign w_start = (r_state == S_IDLE) && !w_rxs;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Oversample tick divider, re-phased to the start edge so ticks land mid-bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_div <= '0;
    else if (w_start || w_tick) r_div <= '0;
    else r_div <= r_div + DW'(1);
  end

  // Receiver state and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_scnt  <= 4'd0;
      r_bcnt  <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Frame recovery: mid-start check, 16-tick data sampling, stop-bit validation
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_push_req  = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_scnt_nxt  = 4'd0;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_scnt == 4'd7) begin
            if (w_rxs) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DATA;
              w_scnt_nxt  = 4'd0;
              w_bcnt_nxt  = 3'd0;
            end
          end else begin
            w_scnt_nxt = r_scnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_scnt_nxt = r_scnt + 4'd1;
          if (r_scnt == 4'd15) begin
            w_shift_nxt = {w_rxs, r_shift[7:1]};
            w_bcnt_nxt  = r_bcnt + 3'd1;
            if (r_bcnt == 3'd7) w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_scnt_nxt = r_scnt + 4'd1;
          if (r_scnt == 4'd15) begin
            w_state_nxt = S_IDLE;
            if (w_rxs) w_push_req = 1'b1;
            else       w_ferr_set = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered push request; the FIFO write happens one clock after the stop sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_push      <= 1'b0;
      r_push_data <= 8'd0;
    end else begin
      r_push      <= w_push_req;
      r_push_data <= r_shift;
    end
  end

  assign w_full    = (r_level == FULL_LEVEL);
  assign w_empty   = (r_level == '0);
  assign w_do_pop  = pop && !w_empty;
  assign w_do_push = r_push && (!w_full || w_do_pop);
  assign w_ovr_set = r_push && w_full && !w_do_pop;

  // FIFO storage; contents past the read pointer are never shown, so no reset needed
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= r_push_data;
  end

  // FIFO pointers and explicit occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_do_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      if (w_do_push && !w_do_pop)      r_level <= r_level + LW'(1);
      else if (w_do_pop && !w_do_push) r_level <= r_level - LW'(1);
    end
  end

  // Sticky error flags; a set in the same cycle as a clear takes priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_ferr_set)   r_ferr <= 1'b1;
      else if (clr_err) r_ferr <= 1'b0;
      if (w_ovr_set)    r_ovr  <= 1'b1;
      else if (clr_err) r_ovr  <= 1'b0;
    end
  end

  assign rx_valid  = !w_empty;
  assign rx_data   = w_empty ? 8'h00 : r_mem[r_rptr];
  assign level     = r_level;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign irq       = rx_valid | r_ferr | r_ovr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with a queue-based FIFO model
module tb_uart_rx_fifo;
  localparam int DIV   = 4;
  localparam int BC    = 16 * DIV;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, din, pop, clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] level;
  logic       frame_err, overrun, irq;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DIVISOR(DIV), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .din(din), .pop(pop), .clr_err(clr_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .level(level),
    .frame_err(frame_err), .overrun(overrun), .irq(irq)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  bit         exp_ovr = 1'b0;
  bit         exp_ferr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model of the receive path: a good byte lands if there is room, else it is an overrun
  task automatic model_arrive(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic check_state(input string tag);
    bit nonempty;
    nonempty = (exp_q.size() > 0);
    chk({tag, ".level"}, level, exp_q.size());
    chk({tag, ".rx_valid"}, rx_valid, nonempty);
    chk({tag, ".frame_err"}, frame_err, exp_ferr);
    chk({tag, ".overrun"}, overrun, exp_ovr);
    chk({tag, ".irq"}, irq, nonempty || exp_ferr || exp_ovr);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    wait_cyc(1);
    pop = 1'b0;
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // A bad stop is held low for 3/4 bit so the follow-on low is rejected as a glitch
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bc);
    din = 1'b0;
    wait_cyc(bc);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      wait_cyc(bc);
    end
    if (stop_ok) begin
      din = 1'b1;
      wait_cyc(bc);
      model_arrive(b);
    end else begin
      din = 1'b0;
      wait_cyc(bc * 3 / 4);
      din = 1'b1;
      exp_ferr = 1'b1;
    end
  endtask

  // Monitor: every effective pop must return the scoreboard head
  always @(negedge clk) begin
    if (!reset && pop && rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_data: got 0x%0h expected no data", rx_data);
      end else begin
        chk("pop_data", rx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit         done;
    bit         seen;
    logic [7:0] rb;
    int         bc;

    reset = 1'b1; din = 1'b1; pop = 1'b0; clr_err = 1'b0;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(2);
    check_state("reset");
    chk("reset.rx_data", rx_data, 8'h00);

    // Single byte
    send_frame(8'hA5, 1'b1, BC);
    check_state("single");
    chk("single.head", rx_data, 8'hA5);
    do_pop();
    check_state("single_pop");
    chk("single_pop.rx_data", rx_data, 8'h00);

    // Fill to depth and overrun with a fifth byte
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, BC);
    check_state("fill");
    for (int i = 0; i < 4; i++) do_pop();
    check_state("drain");
    do_clr();
    check_state("clr_ovr");

    // Framing error, then a normal byte
    send_frame(8'h3C, 1'b0, BC);
    wait_cyc(BC);
    check_state("frame_err");
    send_frame(8'h7E, 1'b1, BC);
    check_state("after_ferr");
    do_pop();
    do_clr();
    check_state("clr_ferr");

    // Glitch shorter than half a bit
    din = 1'b0;
    wait_cyc(5 * DIV);
    din = 1'b1;
    wait_cyc(2 * BC);
    check_state("glitch");
    send_frame(8'h5A, 1'b1, BC);
    check_state("post_glitch");
    do_pop();

    // Pop while empty
    do_pop();
    check_state("pop_empty");
    chk("pop_empty.rx_data", rx_data, 8'h00);

    // Full FIFO with a pop landing on the same clock as the write of 0x99
    for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, BC);
    check_state("refill");
    done = 1'b0;
    fork
      send_frame(8'h99, 1'b1, BC);
      begin
        for (int k = 0; k < 1500 && !done; k++) begin
          wait_cyc(1);
          if (dut.r_push) begin
            pop = 1'b1;
            wait_cyc(1);
            pop = 1'b0;
            done = 1'b1;
          end
        end
      end
    join
    chk("push_pop_aligned", done, 1'b1);
    check_state("push_pop_full");
    chk("push_pop_tail", exp_q.size() > 0 ? exp_q[exp_q.size()-1] : 8'h00, 8'h99);
    for (int i = 0; i < 4; i++) do_pop();
    check_state("push_pop_drain");

    // clr_err held across a new frame error: the set must win
    seen = 1'b0;
    clr_err = 1'b1;
    fork
      send_frame(8'h3C, 1'b0, BC);
      begin
        for (int k = 0; k < 1000 && !seen; k++) begin
          wait_cyc(1);
          if (frame_err) seen = 1'b1;
        end
        clr_err = 1'b0;
      end
    join
    wait_cyc(BC);
    chk("ferr_set_wins", seen, 1'b1);
    check_state("ferr_race");

    // Reset during bit 4 with data buffered and an error pending
    send_frame(8'h55, 1'b1, BC);
    rb = 8'h6B;
    din = 1'b0;
    wait_cyc(BC);
    for (int i = 0; i < 4; i++) begin
      din = rb[i];
      wait_cyc(BC);
    end
    din = rb[4];
    wait_cyc(BC / 2);
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
    check_state("in_reset");
    chk("in_reset.rx_data", rx_data, 8'h00);
    wait_cyc(5);
    din = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2 * BC);
    check_state("post_reset");
    send_frame(8'h42, 1'b1, BC);
    wait_cyc(2 * BC);
    check_state("post_reset_byte");
    do_pop();
    check_state("post_reset_pop");

    // Randomized bytes with bit periods within about 2% of nominal
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      bc = $urandom_range(BC - 1, BC + 1);
      send_frame(rb, 1'b1, bc);
      if ($urandom_range(0, 2) != 0) do_pop();
    end
    check_state("random");
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) do_pop();
    check_state("random_drain");
    do_clr();
    check_state("final");
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
